z80_ir_unit: RTL

Parametrised I/R special-register unit for the Z80 core: holds the interrupt-vector register I and memory-refresh register R. Executes the LD I,A / LD R,A writes and the LD A,I / LD A,R reads with Z80 flag generation. Auto-increments R on every M1 opcode fetch and sequences the refresh-address window. It sits beside the main register file and is driven by the M-cycle sequencer.

---
 rtl/z80_ir_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/z80_ir_unit.sv
// ---------------------------------------------------------------------------
// z80_ir_unit
//
// I/R special-register unit of the Z80 core. It holds the interrupt-vector
// register I and the memory-refresh register R, executes LD I,A / LD R,A and
// LD A,I / LD A,R (including Z80 flag generation), auto-increments the low
// bits of R on every M1 opcode fetch and times the refresh-address window.
//
// Handshake: every strobe input is a single-clock pulse that is always
// accepted (there is no ready/back-pressure). Each output "valid" is a
// registered single-clock pulse or level that qualifies its data bus.
//
// Parameters
//   R_INC_BITS     low R bits that auto-increment (1..8); upper bits are kept
//   REFRESH_CYCLES refresh window length in clocks (1..15)
//   RESET_I        reset value of I
//   RESET_R        reset value of R
//
// Ports
//   clk, reset       core clock, asynchronous active-high reset
//   m1_fetch         pulse per completed M1 opcode fetch (prefixes included)
//   ld_i_a, ld_r_a   load I / R from a_in
//   a_in             current accumulator
//   rd_req, rd_sel   LD A,I (rd_sel=0) or LD A,R (rd_sel=1)
//   f_in, iff2       current F and IFF2, sampled with rd_req
//   a_out, f_out     read result, qualified by rd_valid (held until next read)
//   rd_valid         one-clock pulse one clock after rd_req
//   refresh_start    pulse at M1 T3, opens the refresh window
//   refresh_addr     {I, R} latched at refresh_start
//   refresh_valid    high for the duration of the refresh window
//   reg_i, reg_r     current I and R
// ---------------------------------------------------------------------------
module z80_ir_unit #(
    parameter int          R_INC_BITS     = 7,
    parameter int          REFRESH_CYCLES = 2,
    parameter logic [7:0]  RESET_I        = 8'h00,
    parameter logic [7:0]  RESET_R        = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_fetch,
    input  logic        ld_i_a,
    input  logic        ld_r_a,
    input  logic [7:0]  a_in,
    input  logic        rd_req,
    input  logic        rd_sel,
    input  logic [7:0]  f_in,
    input  logic        iff2,
    output logic [7:0]  a_out,
    output logic [7:0]  f_out,
    output logic        rd_valid,
    input  logic        refresh_start,
    output logic [15:0] refresh_addr,
    output logic        refresh_valid,
    output logic [7:0]  reg_i,
    output logic [7:0]  reg_r
);

    // Mask of the R bits that take part in the auto-increment. A 9-bit
    // intermediate keeps R_INC_BITS=8 from overflowing the shift.
    localparam logic [8:0] INC_ONE  = 9'd1 << R_INC_BITS;
    localparam logic [7:0] INC_MASK = 8'(INC_ONE - 9'd1);

    // Counter reload value: the window lasts CNT_LOAD+1 clocks.
    localparam logic [3:0] CNT_LOAD = 4'(REFRESH_CYCLES - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } refresh_state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0]     i_q, i_d;
    logic [7:0]     r_q, r_d;
    logic [7:0]     a_out_q, a_out_d;
    logic [7:0]     f_out_q, f_out_d;
    logic           rd_valid_q, rd_valid_d;
    logic [15:0]    refresh_addr_q, refresh_addr_d;
    logic [3:0]     cnt_q, cnt_d;
    refresh_state_t state_q, state_d;

    // Read source and the value R takes on an increment
    logic [7:0]     r_inc;
    logic [7:0]     rd_val;

    // -----------------------------------------------------------------------
    // I/R register update
    // -----------------------------------------------------------------------
    always_comb begin
        r_inc = (r_q & ~INC_MASK) | ((r_q + 8'd1) & INC_MASK);

        i_d = i_q;
        if (ld_i_a) begin
            i_d = a_in;
        end

        // An explicit write takes priority over the fetch increment.
        r_d = r_q;
        if (ld_r_a) begin
            r_d = a_in;
        end else if (m1_fetch) begin
            r_d = r_inc;
        end
    end

    // -----------------------------------------------------------------------
    // LD A,I / LD A,R: reads see this cycle's write/increment (bypass).
    // -----------------------------------------------------------------------
    always_comb begin
        rd_val     = rd_sel ? r_d : i_d;
        a_out_d    = a_out_q;
        f_out_d    = f_out_q;
        rd_valid_d = rd_req;
        if (rd_req) begin
            a_out_d = rd_val;
            // S Z Y H X P/V N C
            f_out_d = {rd_val[7], (rd_val == 8'h00), rd_val[5], 1'b0,
                       rd_val[3], iff2, 1'b0, f_in[0]};
        end
    end

    // -----------------------------------------------------------------------
    // Refresh window FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        refresh_addr_d = refresh_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (refresh_start) begin
                    state_d        = ST_ACTIVE;
                    cnt_d          = CNT_LOAD;
                    refresh_addr_d = {i_d, r_d};
                end
            end
            ST_ACTIVE: begin
                if (refresh_start) begin
                    // Restart: re-latch the address and reload the window.
                    cnt_d          = CNT_LOAD;
                    refresh_addr_d = {i_d, r_d};
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q            <= RESET_I;
            r_q            <= RESET_R;
            a_out_q        <= 8'h00;
            f_out_q        <= 8'h00;
            rd_valid_q     <= 1'b0;
            refresh_addr_q <= 16'h0000;
            cnt_q          <= 4'd0;
        end else begin
            i_q            <= i_d;
            r_q            <= r_d;
            a_out_q        <= a_out_d;
            f_out_q        <= f_out_d;
            rd_valid_q     <= rd_valid_d;
            refresh_addr_q <= refresh_addr_d;
            cnt_q          <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from flops; refresh_valid is the state bit, so
    // it drops as soon as reset asserts)
    // -----------------------------------------------------------------------
    assign reg_i         = i_q;
    assign reg_r         = r_q;
    assign a_out         = a_out_q;
    assign f_out         = f_out_q;
    assign rd_valid      = rd_valid_q;
    assign refresh_addr  = refresh_addr_q;
    assign refresh_valid = (state_q == ST_ACTIVE);

endmodule
